pc_unit: RTL and testbench

- Parametrised program-counter unit for the datapath; successor to the fixed 32-bit PC register.
- Adds configurable width, increment step and reset vector, plus PC-relative branch with a sign-extended offset.
- Adds stall and a small return-address stack (RAS) for call/return.
- Sits on the internal bus: loads from BusMuxOut, drives BusMuxIn into the bus multiplexer when Rout is high.

---
 rtl/pc_unit_pkg.sv | 22 ++
 rtl/pc_ras_stack.sv | 71 +++++++
 rtl/pc_unit.sv | 105 ++++++++++
 tb/tb_pc_unit.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit.
//   ACT_*      : action codes produced by the per-edge priority encoder.
//   signExtend : sign-extends the low fromWidth bits of a value to 64 bits.
package pc_unit_pkg;

  localparam logic [2:0] ACT_HOLD   = 3'd0;
  localparam logic [2:0] ACT_INC    = 3'd1;
  localparam logic [2:0] ACT_BRANCH = 3'd2;
  localparam logic [2:0] ACT_LOAD   = 3'd3;
  localparam logic [2:0] ACT_PUSH   = 3'd4;
  localparam logic [2:0] ACT_POP    = 3'd5;
  localparam logic [2:0] ACT_STALL  = 3'd6;

  // Move the sign bit to bit 63, then shift it back arithmetically.
  function automatic logic [63:0] signExtend(input logic [63:0] value,
                                             input int unsigned fromWidth);
    logic signed [63:0] shifted;
    shifted = value << (64 - fromWidth);
    return shifted >>> (64 - fromWidth);
  endfunction

endpackage

// File: rtl/pc_ras_stack.sv
// Circular return-address stack.
//   clock, clear       : clock and asynchronous active-high reset
//   push, pop          : one-cycle requests, already priority-resolved and stall-gated
//   pushData           : return address written on push
//   topData            : most recent entry (stack[sp-1])
//   count, full, empty : occupancy
//   overflow/underflow : combinational strobes for push-when-full / pop-when-empty
module pc_ras_stack
  import pc_unit_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           pushData,
  output logic [WIDTH-1:0]           topData,
  output logic [$clog2(RAS_DEPTH):0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PtrW-1:0]  spQ, spD, topIdx;
  logic [PtrW:0]    countQ, countD;

  assign full      = (countQ == (PtrW + 1)'(RAS_DEPTH));
  assign empty     = (countQ == '0);
  assign count     = countQ;
  assign overflow  = push & full;
  assign underflow = pop & empty;
  assign topIdx    = spQ - 1'b1;
  assign topData   = mem[topIdx];

  always_comb begin
    spD    = spQ;
    countD = countQ;
    if (pop) begin
      if (!empty) begin
        spD    = spQ - 1'b1;
        countD = countQ - 1'b1;
      end
    end else if (push) begin
      // When full the pointer still advances, overwriting the oldest entry.
      spD = spQ + 1'b1;
      if (!full) countD = countQ + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      spQ    <= '0;
      countQ <= '0;
    end else begin
      spQ    <= spD;
      countQ <= countD;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clock) begin
    if (push && !pop) mem[spQ] <= pushData;
  end

endmodule

// File: rtl/pc_unit.sv
// Parametrised program counter with branch, stall and return-address stack.
//   clock, clear  : clock and asynchronous active-high reset
//   Rin/Rout      : load PC from BusMuxOut / drive PC onto BusMuxIn
//   Inc, Branch   : PC += STEP / PC += sext(Offset)
//   Push, Pop     : call (save PC+STEP, jump to BusMuxOut) / return
//   Stall         : freeze PC, RAS and fault flag
//   pc_value      : registered PC; ras_* : stack status, ras_fault sticky
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned       STEP         = 1,
  parameter int unsigned       OFFSET_WIDTH = 19,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       Rin,
  input  logic                       Rout,
  input  logic                       Inc,
  input  logic                       Branch,
  input  logic [OFFSET_WIDTH-1:0]    Offset,
  input  logic                       Push,
  input  logic                       Pop,
  input  logic                       Stall,
  input  logic [WIDTH-1:0]           BusMuxOut,
  output logic [WIDTH-1:0]           BusMuxIn,
  output logic [WIDTH-1:0]           pc_value,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_empty,
  output logic                       ras_full,
  output logic                       ras_fault
);

  localparam logic [WIDTH-1:0] StepW = WIDTH'(STEP);

  logic [WIDTH-1:0] pcQ, pcD, offsetExt, retAddr, rasTop;
  logic [2:0]       action;
  logic             faultQ, faultD;
  logic             rasPush, rasPop, rasOverflow, rasUnderflow;

  // Offset is zero-padded to 64 bits then sign-extended from its own MSB (WIDTH <= 64).
  assign offsetExt = WIDTH'(signExtend(64'(Offset), OFFSET_WIDTH));
  assign retAddr   = pcQ + StepW;

  always_comb begin
    action = ACT_HOLD;
    if (Stall)       action = ACT_STALL;
    else if (Pop)    action = ACT_POP;
    else if (Push)   action = ACT_PUSH;
    else if (Rin)    action = ACT_LOAD;
    else if (Branch) action = ACT_BRANCH;
    else if (Inc)    action = ACT_INC;
  end

  assign rasPush = (action == ACT_PUSH);
  assign rasPop  = (action == ACT_POP);

  pc_ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .clear     (clear),
    .push      (rasPush),
    .pop       (rasPop),
    .pushData  (retAddr),
    .topData   (rasTop),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty),
    .overflow  (rasOverflow),
    .underflow (rasUnderflow)
  );

  always_comb begin
    pcD = pcQ;
    unique case (action)
      ACT_POP:    if (!ras_empty) pcD = rasTop;
      ACT_PUSH:   pcD = BusMuxOut;
      ACT_LOAD:   pcD = BusMuxOut;
      ACT_BRANCH: pcD = pcQ + offsetExt;
      ACT_INC:    pcD = pcQ + StepW;
      default:    pcD = pcQ;
    endcase
  end

  assign faultD = faultQ | rasOverflow | rasUnderflow;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      pcQ    <= RESET_VECTOR;
      faultQ <= 1'b0;
    end else begin
      pcQ    <= pcD;
      faultQ <= faultD;
    end
  end

  assign pc_value  = pcQ;
  assign ras_fault = faultQ;
  assign BusMuxIn  = Rout ? pcQ : '0;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  import pc_unit_pkg::*;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        Rin = 0, Rout = 0, Inc = 0, Branch = 0, Push = 0, Pop = 0, Stall = 0;
  logic [18:0] Offset = '0;
  logic [31:0] BusMuxOut = '0;
  logic [31:0] BusMuxIn, pc_value;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, ras_fault;

  int checks = 0;
  int errors = 0;

  // Reference model: PC as a plain 32-bit number, RAS as a bounded queue.
  logic [31:0] mPc;
  logic [31:0] mRas[$];
  bit          mFault;

  pc_unit #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h40),
    .STEP         (1),
    .OFFSET_WIDTH (19),
    .RAS_DEPTH    (4)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .Rin       (Rin),
    .Rout      (Rout),
    .Inc       (Inc),
    .Branch    (Branch),
    .Offset    (Offset),
    .Push      (Push),
    .Pop       (Pop),
    .Stall     (Stall),
    .BusMuxOut (BusMuxOut),
    .BusMuxIn  (BusMuxIn),
    .pc_value  (pc_value),
    .ras_count (ras_count),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_fault (ras_fault)
  );

  always #5 clock = ~clock;

  task automatic modelStep(input bit inc, br, rin, push, pop, stall,
                           input logic [31:0] bus, input logic [18:0] off);
    if (stall) return;
    if (pop) begin
      if (mRas.size() > 0) mPc = mRas.pop_back();
      else mFault = 1;
    end else if (push) begin
      if (mRas.size() == 4) begin
        void'(mRas.pop_front());
        mFault = 1;
      end
      mRas.push_back(mPc + 32'd1);
      mPc = bus;
    end else if (rin) mPc = bus;
    else if (br) mPc = mPc + 32'(int'($signed(off)));
    else if (inc) mPc = mPc + 32'd1;
  endtask

  // Drive one set of requests for exactly one rising edge, then release them.
  task automatic cycle(input bit inc, br, rin, push, pop, stall,
                       input logic [31:0] bus, input logic [18:0] off);
    @(negedge clock);
    Inc = inc; Branch = br; Rin = rin; Push = push; Pop = pop; Stall = stall;
    BusMuxOut = bus; Offset = off;
    @(posedge clock);
    modelStep(inc, br, rin, push, pop, stall, bus, off);
    #1;
    Inc = 0; Branch = 0; Rin = 0; Push = 0; Pop = 0; Stall = 0;
  endtask

  // Assert clear mid-cycle and leave it high; caller checks then calls releaseClear.
  task automatic assertClear();
    @(negedge clock);
    #2 clear = 1'b1;
    mPc = 32'h40; mRas.delete(); mFault = 0;
    #1;
  endtask

  task automatic releaseClear();
    clear = 1'b0;
  endtask

  task automatic doReset();
    assertClear();
    releaseClear();
  endtask

  task automatic test_reset();
    cycle(0, 0, 1, 0, 0, 0, 32'h1234, '0);
    cycle(0, 0, 0, 1, 0, 0, 32'h55, '0);
    assertClear();
    checks++;
    if (pc_value !== 32'h40) begin
      errors++; $display("FAIL reset_pc got %h want %h", pc_value, 32'h40);
    end
    checks++;
    if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_fault !== 1'b0 || ras_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_ras got e%b f%b flt%b c%0d want e1 f0 flt0 c0",
               ras_empty, ras_full, ras_fault, ras_count);
    end
    // clear must dominate a load request sampled while it is held.
    @(negedge clock); Rin = 1; BusMuxOut = 32'h99;
    @(posedge clock); #1; Rin = 0;
    checks++;
    if (pc_value !== 32'h40) begin
      errors++; $display("FAIL reset_dominates got %h want %h", pc_value, 32'h40);
    end
    releaseClear();
  endtask

  task automatic test_load_inc();
    doReset();
    cycle(0, 0, 1, 0, 0, 0, 32'd100, '0);
    checks++;
    if (pc_value !== 32'd100) begin
      errors++; $display("FAIL load got %0d want 100", pc_value);
    end
    cycle(1, 0, 0, 0, 0, 0, 32'd0, '0);
    checks++;
    if (pc_value !== 32'd101) begin
      errors++; $display("FAIL inc got %0d want 101", pc_value);
    end
    Rout = 0; #1;
    checks++;
    if (BusMuxIn !== 32'd0) begin
      errors++; $display("FAIL rout0 got %h want 0", BusMuxIn);
    end
    Rout = 1; #1;
    checks++;
    if (BusMuxIn !== 32'd101) begin
      errors++; $display("FAIL rout1 got %0d want 101", BusMuxIn);
    end
    Rout = 0;
  endtask

  task automatic test_branch();
    logic [18:0] off;
    doReset();
    cycle(0, 0, 1, 0, 0, 0, 32'd200, '0);
    off = 19'h7FFF8; // -8
    cycle(0, 1, 0, 0, 0, 0, 32'd0, off);
    checks++;
    if (pc_value !== 32'd192) begin
      errors++; $display("FAIL branch_neg got %0d want 192", pc_value);
    end
    off = 19'h3FFFF; // largest positive displacement
    cycle(0, 1, 0, 0, 0, 0, 32'd0, off);
    checks++;
    if (pc_value !== 32'd192 + 32'h3FFFF) begin
      errors++; $display("FAIL branch_pos got %h want %h", pc_value, 32'd192 + 32'h3FFFF);
    end
    cycle(0, 0, 1, 0, 0, 0, 32'hFFFF_FFFE, '0);
    cycle(1, 0, 0, 0, 0, 0, 32'd0, '0);
    checks++;
    if (pc_value !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_inc1 got %h want ffffffff", pc_value);
    end
    cycle(1, 0, 0, 0, 0, 0, 32'd0, '0);
    checks++;
    if (pc_value !== 32'h0) begin
      errors++; $display("FAIL wrap_inc2 got %h want 0", pc_value);
    end
  endtask

  task automatic test_call_return();
    doReset();
    cycle(0, 0, 1, 0, 0, 0, 32'h10, '0);
    cycle(0, 0, 0, 1, 0, 0, 32'h80, '0);
    checks++;
    if (pc_value !== 32'h80 || ras_count !== 3'd1) begin
      errors++; $display("FAIL call got pc %h cnt %0d want pc 80 cnt 1", pc_value, ras_count);
    end
    cycle(0, 0, 0, 0, 1, 0, 32'h0, '0);
    checks++;
    if (pc_value !== 32'h11 || ras_empty !== 1'b1 || ras_fault !== 1'b0) begin
      errors++;
      $display("FAIL return got pc %h e%b flt%b want pc 11 e1 flt0", pc_value, ras_empty, ras_fault);
    end
    // Return address of an all-ones PC wraps.
    cycle(0, 0, 1, 0, 0, 0, 32'hFFFF_FFFF, '0);
    cycle(0, 0, 0, 1, 0, 0, 32'h20, '0);
    cycle(0, 0, 0, 0, 1, 0, 32'h0, '0);
    checks++;
    if (pc_value !== 32'h0) begin
      errors++; $display("FAIL ret_wrap got %h want 0", pc_value);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] want [4];
    want[0] = 32'h41; want[1] = 32'h31; want[2] = 32'h21; want[3] = 32'h11;
    doReset();
    cycle(0, 0, 1, 0, 0, 0, 32'h0, '0);
    for (int i = 1; i <= 5; i++) cycle(0, 0, 0, 1, 0, 0, 32'(i * 16), '0);
    checks++;
    if (ras_full !== 1'b1 || ras_fault !== 1'b1 || ras_count !== 3'd4) begin
      errors++;
      $display("FAIL overflow got full%b flt%b cnt%0d want full1 flt1 cnt4",
               ras_full, ras_fault, ras_count);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 1, 0, 32'h0, '0);
      checks++;
      if (pc_value !== want[i]) begin
        errors++; $display("FAIL overflow_pop%0d got %h want %h", i, pc_value, want[i]);
      end
    end
    cycle(0, 0, 0, 0, 1, 0, 32'h0, '0);
    checks++;
    if (pc_value !== 32'h11 || ras_fault !== 1'b1 || ras_count !== 3'd0) begin
      errors++;
      $display("FAIL underflow got pc %h flt%b cnt%0d want pc 11 flt1 cnt0",
               pc_value, ras_fault, ras_count);
    end
  endtask

  task automatic test_priority_stall();
    doReset();
    cycle(1, 1, 1, 0, 0, 0, 32'd7, 19'd100);
    checks++;
    if (pc_value !== 32'd7) begin
      errors++; $display("FAIL prio_rin got %0d want 7", pc_value);
    end
    cycle(1, 0, 0, 1, 0, 0, 32'h300, '0);
    checks++;
    if (pc_value !== 32'h300 || ras_count !== 3'd1) begin
      errors++; $display("FAIL prio_push got pc %h cnt %0d want 300 1", pc_value, ras_count);
    end
    cycle(1, 0, 0, 0, 1, 1, 32'h0, '0);
    checks++;
    if (pc_value !== 32'h300 || ras_count !== 3'd1) begin
      errors++; $display("FAIL stall got pc %h cnt %0d want 300 1", pc_value, ras_count);
    end
    cycle(0, 0, 0, 1, 1, 0, 32'h500, '0);
    checks++;
    if (pc_value !== 32'd8 || ras_count !== 3'd0) begin
      errors++; $display("FAIL prio_pop got pc %h cnt %0d want 8 0", pc_value, ras_count);
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0, 32'(i + 3), '0);
    cycle(0, 0, 0, 0, 0, 0, 32'h0, '0);
    checks++;
    if (ras_count !== 3'd3) begin
      errors++; $display("FAIL mid_fill got %0d want 3", ras_count);
    end
    cycle(0, 0, 0, 0, 1, 0, 32'h0, '0); // set up a fault by popping to empty later
    assertClear();
    checks++;
    if (ras_count !== 3'd0 || ras_fault !== 1'b0 || pc_value !== 32'h40) begin
      errors++;
      $display("FAIL mid_clear got cnt %0d flt%b pc %h want 0 0 40", ras_count, ras_fault, pc_value);
    end
    releaseClear();
    cycle(0, 0, 0, 0, 1, 0, 32'h0, '0);
    checks++;
    if (ras_fault !== 1'b1 || pc_value !== 32'h40) begin
      errors++; $display("FAIL mid_underflow got flt%b pc %h want 1 40", ras_fault, pc_value);
    end
  endtask

  task automatic test_random();
    logic [2:0] act;
    bit inc, br, rin, push, pop, stall;
    logic [31:0] exp;
    doReset();
    for (int n = 0; n < 300; n++) begin
      act   = 3'($urandom_range(0, 6));
      inc   = ($urandom_range(0, 2) == 0) || (act == ACT_INC);
      br    = ($urandom_range(0, 3) == 0) || (act == ACT_BRANCH);
      rin   = ($urandom_range(0, 4) == 0) || (act == ACT_LOAD);
      push  = ($urandom_range(0, 5) == 0) || (act == ACT_PUSH);
      pop   = ($urandom_range(0, 5) == 0) || (act == ACT_POP);
      stall = (act == ACT_STALL);
      cycle(inc, br, rin, push, pop, stall, $urandom, 19'($urandom));
      Rout = 1'($urandom); #1;
      exp = Rout ? mPc : 32'h0;
      checks++;
      if (pc_value !== mPc || ras_count !== 3'(mRas.size()) || ras_fault !== mFault ||
          ras_full !== (mRas.size() == 4) || ras_empty !== (mRas.size() == 0) ||
          BusMuxIn !== exp) begin
        errors++;
        $display("FAIL random%0d got pc %h cnt %0d flt%b bus %h want pc %h cnt %0d flt%b bus %h",
                 n, pc_value, ras_count, ras_fault, BusMuxIn, mPc, mRas.size(), mFault, exp);
      end
    end
    Rout = 0;
  endtask

  initial begin
    mPc = 32'h40; mFault = 0;
    test_reset();
    test_load_inc();
    test_branch();
    test_call_return();
    test_overflow();
    test_priority_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
